song_stream_controller: RTL and testbench

//  Parametrised song playback engine: selects one of NUM_SONGS songs in SDRAM and reads its length word.

---
 rtl/song_stream_controller_if.sv | 16 +
 rtl/song_stream_controller.sv | 233 +++++++++++++++++++++++
 tb/tb_song_stream_controller.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/song_stream_controller_if.sv
// Avalon-style master read port between song_stream_controller and SDRAM.
//   tl_read  : read request, held until tl_rdv
//   tl_addr  : byte address, valid while tl_read
//   tl_rdv   : read data valid, completes the outstanding read
//   tl_data  : read data, valid with tl_rdv
interface song_stream_controller_if #(
  parameter int unsigned DATA_W = 32
);
  logic              tl_read;
  logic [31:0]       tl_addr;
  logic              tl_rdv;
  logic [DATA_W-1:0] tl_data;

  modport master (output tl_read, tl_addr, input  tl_rdv, tl_data);
  modport slave  (input  tl_read, tl_addr, output tl_rdv, tl_data);
endinterface

// File: rtl/song_stream_controller.sv
// Song playback engine: reads the selected song's length word, streams its
// samples from SDRAM into a prefetch FIFO and serves them to the audio side.
// Supports pause, abort, loop mode and saturating underrun accounting.
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_start, i_stop    begin playback of i_song_sel / abort playback
//   i_pause, i_loop_en level controls: freeze fetch+serve / restart at song end
//   i_song_sel         song index, sampled on accepted start
//   i_sample_req       audio side requests next sample (pulse)
//   o_sample_out       last served sample; o_sample_valid pulses on update
//   o_waiting, o_busy  IDLE / not IDLE
//   o_done             pulse on natural song end
//   o_samples_left     samples still to fetch in the current pass
//   o_underrun_cnt     saturating count of requests seen with an empty FIFO
//   tl                 Avalon master read port
module song_stream_controller #(
  parameter int unsigned NUM_SONGS   = 4,
  parameter int unsigned SEL_W       = 2,
  parameter logic [31:0] SONG_STRIDE = 32'h003E_0000,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_pause,
  input  logic              i_loop_en,
  input  logic [SEL_W-1:0]  i_song_sel,
  input  logic              i_sample_req,
  output logic [DATA_W-1:0] o_sample_out,
  output logic              o_sample_valid,
  output logic              o_waiting,
  output logic              o_busy,
  output logic              o_done,
  output logic [31:0]       o_samples_left,
  output logic [15:0]       o_underrun_cnt,
  song_stream_controller_if.master tl
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_RD, S_FETCH, S_DRAIN, S_FIN, S_ABORT
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_tl_read;
  logic [31:0]       r_tl_addr;
  logic [31:0]       r_base;
  logic [31:0]       r_ptr;
  logic [31:0]       r_samples_left;
  logic [15:0]       r_underrun_cnt;
  logic [DATA_W-1:0] r_sample_out;
  logic              r_sample_valid;
  logic              r_done;
  logic              r_waiting;
  logic              r_busy;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic              w_rd_done;
  logic [31:0]       w_start_base;
  logic              w_issue;
  logic [31:0]       w_issue_addr;
  logic              w_len_latch;
  logic              w_push;
  logic              w_flush;
  logic              w_start_acc;
  logic              w_serve;
  logic              w_pop;
  logic              w_underrun;

  assign w_rd_done    = r_tl_read & tl.tl_rdv;
  // Out-of-range selections fall back to song 0; product wraps mod 2^32.
  assign w_start_base = (32'(i_song_sel) < NUM_SONGS) ? 32'(32'(i_song_sel) * SONG_STRIDE) : 32'h0;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and datapath strobes; stop overrides every other event.
  always_comb begin
    w_state_nxt  = r_state;
    w_issue      = 1'b0;
    w_issue_addr = r_ptr;
    w_len_latch  = 1'b0;
    w_push       = 1'b0;
    w_flush      = 1'b0;
    w_start_acc  = 1'b0;
    w_serve      = i_sample_req & ~i_pause & ~i_stop &
                   ((r_state == S_FETCH) || (r_state == S_DRAIN));
    w_pop        = w_serve & (r_count != '0);
    w_underrun   = w_serve & (r_count == '0);
    if (i_stop && (r_state != S_IDLE) && (r_state != S_ABORT)) begin
      w_state_nxt = S_ABORT;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            w_state_nxt  = S_LEN_RD;
            w_start_acc  = 1'b1;
            w_issue      = 1'b1;
            w_issue_addr = w_start_base;
          end
        end
        S_LEN_RD: begin
          if (w_rd_done) begin
            w_len_latch = 1'b1;
            if (tl.tl_data == '0) begin
              if (i_loop_en) begin
                w_issue      = 1'b1;
                w_issue_addr = r_base;
              end else begin
                w_state_nxt = S_FIN;
              end
            end else begin
              w_state_nxt = S_FETCH;
            end
          end
        end
        S_FETCH: begin
          // Room is checked at issue; only one read is ever in flight.
          if (w_rd_done) begin
            w_push = 1'b1;
            if (r_samples_left <= 32'd1) w_state_nxt = S_DRAIN;
          end else if (!r_tl_read && !i_pause && (r_count < CW'(FIFO_DEPTH))) begin
            w_issue      = 1'b1;
            w_issue_addr = r_ptr;
          end
        end
        S_DRAIN: begin
          if (r_count == '0) begin
            if (i_loop_en) begin
              w_state_nxt  = S_LEN_RD;
              w_issue      = 1'b1;
              w_issue_addr = r_base;
            end else begin
              w_state_nxt = S_FIN;
            end
          end
        end
        S_FIN:   w_state_nxt = S_IDLE;
        S_ABORT: begin
          // Let an in-flight read finish (data dropped) before flushing.
          if (!r_tl_read || w_rd_done) begin
            w_flush     = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Read port, pointers, counters and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tl_read      <= 1'b0;
      r_tl_addr      <= '0;
      r_base         <= '0;
      r_ptr          <= '0;
      r_samples_left <= '0;
      r_underrun_cnt <= '0;
      r_sample_out   <= '0;
      r_sample_valid <= 1'b0;
      r_done         <= 1'b0;
      r_waiting      <= 1'b1;
      r_busy         <= 1'b0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
    end else begin
      if (w_issue) begin
        r_tl_read <= 1'b1;
        r_tl_addr <= w_issue_addr;
      end else if (w_rd_done) begin
        r_tl_read <= 1'b0;
      end
      if (w_start_acc) begin
        r_base         <= w_start_base;
        r_underrun_cnt <= '0;
      end else if (w_underrun && (r_underrun_cnt != 16'hFFFF)) begin
        r_underrun_cnt <= r_underrun_cnt + 16'd1;
      end
      if (w_len_latch) begin
        r_ptr          <= r_base + 32'd4;
        r_samples_left <= 32'(tl.tl_data);
      end else if (w_push) begin
        r_ptr <= r_ptr + 32'd4;
        if (r_samples_left != '0) r_samples_left <= r_samples_left - 32'd1;
      end
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
      if (w_pop) r_sample_out <= r_mem[r_rd_ptr];
      r_sample_valid <= w_pop;
      r_done         <= (r_state == S_FIN) && !i_stop;
      r_waiting      <= (w_state_nxt == S_IDLE);
      r_busy         <= (w_state_nxt != S_IDLE);
    end
  end

  // FIFO storage.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= tl.tl_data;
  end

  assign tl.tl_read     = r_tl_read;
  assign tl.tl_addr     = r_tl_addr;
  assign o_sample_out   = r_sample_out;
  assign o_sample_valid = r_sample_valid;
  assign o_waiting      = r_waiting;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_samples_left = r_samples_left;
  assign o_underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_song_stream_controller.sv
// Directed bench for song_stream_controller with a latency-programmable
// SDRAM read responder and hand-computed expected values.
module tb_song_stream_controller;

  localparam logic [31:0] STRIDE = 32'h003E_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, pause, loop_en, sample_req;
  logic [1:0]  song_sel;
  logic [31:0] sample_out;
  logic        sample_valid, waiting, busy, done;
  logic [31:0] samples_left;
  logic [15:0] underrun_cnt;

  song_stream_controller_if #(.DATA_W(32)) bus ();

  song_stream_controller #(
    .NUM_SONGS(4), .SEL_W(2), .SONG_STRIDE(STRIDE), .DATA_W(32), .FIFO_DEPTH(8)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_pause(pause),
    .i_loop_en(loop_en), .i_song_sel(song_sel), .i_sample_req(sample_req),
    .o_sample_out(sample_out), .o_sample_valid(sample_valid), .o_waiting(waiting),
    .o_busy(busy), .o_done(done), .o_samples_left(samples_left),
    .o_underrun_cnt(underrun_cnt), .tl(bus)
  );

  always #5 clk = ~clk;

  int          n_checks, n_errors;
  int          cyc, lat, wcnt, done_cnt, rdv_cyc, done_cyc, d0;
  bit          rsp_en;
  logic [31:0] len_tab [4];
  logic [31:0] rd_log [$];
  logic [31:0] sv_log [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Length words live at each song base; any other word is addr ^ 5A5A0000.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    for (int i = 0; i < 4; i++) if (a == 32'(i) * STRIDE) return len_tab[i];
    return a ^ 32'h5A5A_0000;
  endfunction

  initial begin
    cyc = 0;
    forever begin @(posedge clk); cyc++; end
  end

  // Read responder: answers each request after 'lat' wait cycles.
  initial begin
    wcnt = 0;
    bus.tl_rdv  = 1'b0;
    bus.tl_data = '0;
    forever begin
      @(posedge clk); #1;
      bus.tl_rdv = 1'b0;
      if (bus.tl_read && rsp_en && !rst) begin
        if (wcnt >= lat) begin
          bus.tl_rdv  = 1'b1;
          bus.tl_data = mem_word(bus.tl_addr);
          rd_log.push_back(bus.tl_addr);
          rdv_cyc = cyc;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Output monitor.
  initial begin
    done_cnt = 0;
    forever begin
      @(negedge clk);
      if (sample_valid) sv_log.push_back(sample_out);
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] sel);
    @(posedge clk); #1;
    song_sel = sel; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_req();
    sample_req = 1'b1; @(posedge clk); #1; sample_req = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; @(posedge clk); #1; stop = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (!waiting && k < budget) begin @(negedge clk); k++; end
    check(tag, 32'(waiting), 32'd1);
  endtask

  task automatic wait_log(input string tag, input int n, input int budget);
    int k = 0;
    while (rd_log.size() < n && k < budget) begin @(negedge clk); k++; end
    check(tag, 32'(rd_log.size() >= n), 32'd1);
  endtask

  task automatic wait_rd_addr(input string tag, input logic [31:0] a, input int budget);
    int k = 0;
    while (!(bus.tl_read && bus.tl_addr == a) && k < budget) begin @(negedge clk); k++; end
    check(tag, bus.tl_addr, a);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
    sample_req = 1'b0; song_sel = 2'd0; lat = 0; rsp_en = 1'b1;
    rdv_cyc = 0; done_cyc = 0;
    len_tab[0] = 32'd20; len_tab[1] = 32'd3; len_tab[2] = 32'd0; len_tab[3] = 32'd2;
    tick(3);

    // Reset state
    check("rst_waiting",  32'(waiting), 32'd1);
    check("rst_busy",     32'(busy), 32'd0);
    check("rst_done",     32'(done), 32'd0);
    check("rst_valid",    32'(sample_valid), 32'd0);
    check("rst_out",      sample_out, 32'd0);
    check("rst_tl_read",  32'(bus.tl_read), 32'd0);
    check("rst_tl_addr",  bus.tl_addr, 32'd0);
    check("rst_left",     samples_left, 32'd0);
    check("rst_underrun", 32'(underrun_cnt), 32'd0);
    rst = 1'b0;
    tick(2);

    // Song 1, L=3, four requests spaced 4 cycles; the first finds the FIFO empty
    rd_log.delete(); sv_log.delete(); d0 = done_cnt;
    pulse_start(2'd1);
    tick(1);
    repeat (4) begin
      pulse_req();
      tick(3);
    end
    wait_idle("t1_idle", 30);
    check("t1_nreads", 32'(rd_log.size()), 32'd4);
    check("t1_addr0", rd_log[0], 32'h003E_0000);
    check("t1_addr1", rd_log[1], 32'h003E_0004);
    check("t1_addr2", rd_log[2], 32'h003E_0008);
    check("t1_addr3", rd_log[3], 32'h003E_000C);
    check("t1_nsamp", 32'(sv_log.size()), 32'd3);
    check("t1_samp_a", sv_log[0], 32'h5A64_0004);
    check("t1_samp_b", sv_log[1], 32'h5A64_0008);
    check("t1_samp_c", sv_log[2], 32'h5A64_000C);
    check("t1_underrun", 32'(underrun_cnt), 32'd1);
    check("t1_done", 32'(done_cnt - d0), 32'd1);
    check("t1_left", samples_left, 32'd0);

    // Stop in IDLE is ignored
    pulse_stop();
    tick(2);
    check("idle_stop_waiting", 32'(waiting), 32'd1);
    check("idle_stop_busy", 32'(busy), 32'd0);

    // Song 2, L=0: one read, done two cycles after its tl_rdv
    rd_log.delete(); sv_log.delete(); d0 = done_cnt;
    pulse_start(2'd2);
    wait_idle("t2_idle", 20);
    tick(3);
    check("t2_nreads", 32'(rd_log.size()), 32'd1);
    check("t2_addr", rd_log[0], 32'h007C_0000);
    check("t2_done", 32'(done_cnt - d0), 32'd1);
    check("t2_done_lat", 32'(done_cyc - rdv_cyc), 32'd2);
    check("t2_nsamp", 32'(sv_log.size()), 32'd0);
    check("t2_underrun_clr", 32'(underrun_cnt), 32'd0);

    // Song 0, L=20, no requests: FIFO fills after 8 sample reads; start while busy ignored
    rd_log.delete(); sv_log.delete(); d0 = done_cnt;
    pulse_start(2'd0);
    tick(5);
    pulse_start(2'd3);
    tick(60);
    check("t3_nreads", 32'(rd_log.size()), 32'd9);
    check("t3_last_addr", rd_log[8], 32'h0000_0020);
    check("t3_tl_read", 32'(bus.tl_read), 32'd0);
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_left", samples_left, 32'd12);
    pulse_req();
    tick(20);
    check("t3_nreads2", 32'(rd_log.size()), 32'd10);
    check("t3_addr9", rd_log[9], 32'h0000_0024);
    check("t3_nsamp", 32'(sv_log.size()), 32'd1);
    check("t3_samp", sv_log[0], 32'h5A5A_0004);
    check("t3_tl_read2", 32'(bus.tl_read), 32'd0);
    check("t3_left2", samples_left, 32'd11);
    pulse_stop();
    wait_idle("t3_idle", 20);
    check("t3_no_done", 32'(done_cnt - d0), 32'd0);

    // Pause raised while a sample read is in flight
    rd_log.delete(); sv_log.delete(); d0 = done_cnt;
    lat = 3;
    pulse_start(2'd0);
    wait_rd_addr("t4_first_rd", 32'h0000_0004, 60);
    pause = 1'b1;
    tick(15);
    check("t4_nreads", 32'(rd_log.size()), 32'd2);
    check("t4_tl_read", 32'(bus.tl_read), 32'd0);
    check("t4_left", samples_left, 32'd19);
    pulse_req();
    tick(5);
    check("t4_nsamp", 32'(sv_log.size()), 32'd0);
    check("t4_underrun", 32'(underrun_cnt), 32'd0);
    pause = 1'b0;
    wait_log("t4_resume", 3, 40);
    check("t4_resume_addr", rd_log[2], 32'h0000_0008);
    pulse_stop();
    wait_idle("t4_idle", 40);

    // Stop while a read waits 5 cycles for tl_rdv
    rd_log.delete(); sv_log.delete(); d0 = done_cnt;
    lat = 5;
    pulse_start(2'd0);
    wait_rd_addr("t5_rd8", 32'h0000_0008, 80);
    pulse_stop();
    tick(2);
    check("t5_hold_read", 32'(bus.tl_read), 32'd1);
    check("t5_hold_addr", bus.tl_addr, 32'h0000_0008);
    check("t5_busy", 32'(busy), 32'd1);
    wait_idle("t5_idle", 30);
    check("t5_nreads", 32'(rd_log.size()), 32'd3);
    check("t5_tl_read", 32'(bus.tl_read), 32'd0);
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    check("t5_nsamp", 32'(sv_log.size()), 32'd0);

    // Loop mode, song 3, L=2 (first samples also prove the FIFO was flushed)
    rd_log.delete(); sv_log.delete(); d0 = done_cnt;
    lat = 0;
    loop_en = 1'b1;
    pulse_start(2'd3);
    tick(10);
    pulse_req();
    tick(3);
    pulse_req();
    wait_log("t6_reread", 4, 40);
    check("t6_reread_addr", rd_log[3], 32'h00BA_0000);
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
    check("t6_nsamp", 32'(sv_log.size()), 32'd2);
    check("t6_samp0", sv_log[0], 32'h5AE0_0004);
    check("t6_samp1", sv_log[1], 32'h5AE0_0008);
    loop_en = 1'b0;
    tick(10);
    pulse_req();
    tick(3);
    pulse_req();
    wait_idle("t6_idle", 40);
    check("t6_nreads", 32'(rd_log.size()), 32'd6);
    check("t6_done", 32'(done_cnt - d0), 32'd1);
    check("t6_nsamp2", 32'(sv_log.size()), 32'd4);

    // Underrun saturation with a stalled read, then reset mid-read
    rd_log.delete(); sv_log.delete();
    lat = 0;
    pulse_start(2'd0);
    wait_log("t7_len", 1, 20);
    rsp_en = 1'b0;
    sample_req = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    sample_req = 1'b0;
    check("t7_underrun_sat", 32'(underrun_cnt), 32'h0000_FFFF);
    check("t7_pending", 32'(bus.tl_read), 32'd1);
    rst = 1'b1;
    tick(2);
    check("t7_rst_tl_read", 32'(bus.tl_read), 32'd0);
    check("t7_rst_waiting", 32'(waiting), 32'd1);
    check("t7_rst_underrun", 32'(underrun_cnt), 32'd0);
    rst = 1'b0;
    rsp_en = 1'b1;
    tick(5);
    check("t7_post_busy", 32'(busy), 32'd0);
    check("t7_post_tl_read", 32'(bus.tl_read), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
